vector_ldst: RTL and testbench



---
 rtl/vector_ldst.sv | 152 +++++++++++++++
 tb/tb_vector_ldst.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/vector_ldst.sv
// Vector load/store engine: moves one 256-bit vector register to or from
// 16-bit data memory, one element per cycle at BaseAddr + i*Stride.
//
// state     | meaning
// ----------+--------------------------------------------------------
// IDLE      | waiting for start_i
// LD_RD     | 16 memory reads, capturing the previous read's data
// LD_TAIL   | capture the last element
// LD_WB     | single vector-register write of the assembled vector
// ST_VRD    | vector-register read strobe
// ST_CAP    | latch the vector-register read data
// ST_WR     | 16 memory writes, one element per cycle
// DONE      | one-cycle completion pulse; may accept a new start

module vector_ldst #(
  parameter int ELEMS = 16,
  parameter int EW    = 16,
  parameter int AW    = 16
) (
  input  logic                clk_i,
  input  logic                rst_n_i,
  input  logic                start_i,
  input  logic                op_i,
  input  logic [2:0]          vreg_sel_i,
  input  logic [AW-1:0]       base_addr_i,
  input  logic [AW-1:0]       stride_i,
  output logic                busy_o,
  output logic                done_o,
  output logic [AW-1:0]       mem_addr_o,
  output logic                mem_rd_o,
  output logic                mem_wr_o,
  output logic [EW-1:0]       mem_wdata_o,
  input  logic [EW-1:0]       mem_rdata_i,
  output logic [2:0]          vreg_addr_o,
  output logic                vreg_rd_o,
  output logic                vreg_wr_o,
  output logic [ELEMS*EW-1:0] vreg_wdata_o,
  input  logic [ELEMS*EW-1:0] vreg_rdata_i
);

  localparam int VW = ELEMS * EW;
  localparam int CW = $clog2(ELEMS);
  localparam logic [CW-1:0] LAST = CW'(ELEMS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LD_RD, S_LD_TAIL, S_LD_WB,
    S_ST_VRD, S_ST_CAP, S_ST_WR, S_DONE
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    sel_q, sel_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [AW-1:0] stride_q, stride_d;
  logic [VW-1:0] asm_q, asm_d;
  logic [VW-1:0] st_q, st_d;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      sel_q    <= '0;
      addr_q   <= '0;
      stride_q <= '0;
      asm_q    <= '0;
      st_q     <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      sel_q    <= sel_d;
      addr_q   <= addr_d;
      stride_q <= stride_d;
      asm_q    <= asm_d;
      st_q     <= st_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    sel_d       = sel_q;
    addr_d      = addr_q;
    stride_d    = stride_q;
    asm_d       = asm_q;
    st_d        = st_q;
    mem_rd_o    = 1'b0;
    mem_wr_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    vreg_rd_o   = 1'b0;
    vreg_wr_o   = 1'b0;

    unique case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (start_i) begin
          sel_d    = vreg_sel_i;
          addr_d   = base_addr_i;
          stride_d = stride_i;
          cnt_d    = '0;
          if (op_i) begin
            state_d = S_ST_VRD;
          end else begin
            state_d = S_LD_RD;
            asm_d   = '0;
          end
        end
      end
      S_LD_RD: begin
        mem_rd_o   = 1'b1;
        mem_addr_o = addr_q;
        addr_d     = addr_q + stride_q;
        cnt_d      = cnt_q + CW'(1);
        // Elements shift in from the top so element 0 ends up at bits [EW-1:0].
        if (cnt_q != '0) asm_d = {mem_rdata_i, asm_q[VW-1:EW]};
        if (cnt_q == LAST) state_d = S_LD_TAIL;
      end
      S_LD_TAIL: begin
        asm_d   = {mem_rdata_i, asm_q[VW-1:EW]};
        state_d = S_LD_WB;
      end
      S_LD_WB: begin
        vreg_wr_o = 1'b1;
        state_d   = S_DONE;
      end
      S_ST_VRD: begin
        vreg_rd_o = 1'b1;
        state_d   = S_ST_CAP;
      end
      S_ST_CAP: begin
        st_d    = vreg_rdata_i;
        state_d = S_ST_WR;
      end
      S_ST_WR: begin
        mem_wr_o    = 1'b1;
        mem_addr_o  = addr_q;
        mem_wdata_o = st_q[EW-1:0];
        st_d        = st_q >> EW;
        addr_d      = addr_q + stride_q;
        cnt_d       = cnt_q + CW'(1);
        if (cnt_q == LAST) state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign busy_o       = (state_q != S_IDLE) && (state_q != S_DONE);
  assign done_o       = (state_q == S_DONE);
  assign vreg_addr_o  = sel_q;
  assign vreg_wdata_o = asm_q;

endmodule

// File: tb/tb_vector_ldst.sv
// Directed bench for vector_ldst: cycle-by-cycle strobe/address/data checks
// against hand-derived expectations, with simple memory and vreg-file models.

module tb_vector_ldst;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         op = 1'b0;
  logic [2:0]   sel = '0;
  logic [15:0]  base = '0;
  logic [15:0]  stride = '0;
  logic         busy, done, mem_rd, mem_wr, vreg_rd, vreg_wr;
  logic [15:0]  mem_addr, mem_wdata;
  logic [15:0]  mem_rdata = '0;
  logic [2:0]   vreg_addr;
  logic [255:0] vreg_wdata;
  logic [255:0] vreg_rdata = '0;

  logic [255:0] vregs [8];
  int           vwr_cnt = 0;
  int           vectors = 0;
  int           miscompares = 0;

  logic [15:0]  rd_addr [16];
  logic [255:0] last_vw;
  logic [15:0]  last_waddr, last_wdata;
  logic         nxt_op;
  logic [2:0]   nxt_sel;
  logic [15:0]  nxt_base, nxt_stride;

  vector_ldst dut (
    .clk_i(clk), .rst_n_i(rst_n), .start_i(start), .op_i(op),
    .vreg_sel_i(sel), .base_addr_i(base), .stride_i(stride),
    .busy_o(busy), .done_o(done), .mem_addr_o(mem_addr),
    .mem_rd_o(mem_rd), .mem_wr_o(mem_wr), .mem_wdata_o(mem_wdata),
    .mem_rdata_i(mem_rdata), .vreg_addr_o(vreg_addr), .vreg_rd_o(vreg_rd),
    .vreg_wr_o(vreg_wr), .vreg_wdata_o(vreg_wdata), .vreg_rdata_i(vreg_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_rd) mem_rdata <= mem_addr ^ 16'hA5A5;
    if (vreg_rd) vreg_rdata <= vregs[vreg_addr];
    if (vreg_wr) vwr_cnt <= vwr_cnt + 1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic go(input logic o, input logic [2:0] s, input logic [15:0] b, input logic [15:0] st);
    start = 1'b1; op = o; sel = s; base = b; stride = st;
  endtask

  task automatic idle_cycle(input string nm);
    @(negedge clk);
    chk({nm, " idle strobes"}, {busy, done, mem_rd, mem_wr, vreg_rd, vreg_wr}, 6'b0);
    chk({nm, " idle addr"}, {mem_addr, mem_wdata}, 32'h0);
  endtask

  task automatic watch_load(input string nm, input logic [2:0] s, input logic [15:0] b,
                            input logic [15:0] st, input bit poke, input bit hold);
    logic [255:0] expv;
    logic [15:0]  a;
    logic [5:0]   e;
    int           w0;
    for (int i = 0; i < 16; i++) begin
      a = b + 16'(i) * st;
      expv[16*i +: 16] = a ^ 16'hA5A5;
    end
    w0 = vwr_cnt;
    for (int c = 1; c <= 19; c++) begin
      @(negedge clk);
      if (c == 1) begin
        start = 1'b0; op = ~op; sel = ~sel; base = ~base; stride = stride + 16'd7;
      end
      if (poke && (c == 5 || c == 18)) begin start = 1'b1; op = 1'b1; sel = s ^ 3'd5; end
      if (poke && (c == 6 || c == 19)) start = 1'b0;
      if (hold && c == 17) begin
        start = 1'b1; op = nxt_op; sel = nxt_sel; base = nxt_base; stride = nxt_stride;
      end
      e = {1'(c <= 18), 1'(c == 19), 1'(c <= 16), 1'b0, 1'b0, 1'(c == 18)};
      a = (c <= 16) ? b + 16'(c - 1) * st : 16'h0;
      chk($sformatf("%s strobes c%0d", nm, c), {busy, done, mem_rd, mem_wr, vreg_rd, vreg_wr}, e);
      chk($sformatf("%s addr c%0d", nm, c), {mem_addr, mem_wdata}, {a, 16'h0});
      if (c <= 16) rd_addr[c-1] = mem_addr;
      if (c == 18) begin
        last_vw = vreg_wdata;
        chk({nm, " vreg_addr"}, vreg_addr, s);
        chk({nm, " vreg_wdata"}, vreg_wdata, expv);
      end
    end
    chk({nm, " vreg writes"}, vwr_cnt - w0, 1);
  endtask

  task automatic watch_store(input string nm, input logic [2:0] s, input logic [15:0] b,
                             input logic [15:0] st, input logic [15:0] dbase);
    logic [15:0] a, d;
    logic [5:0]  e;
    bit          w;
    for (int c = 1; c <= 19; c++) begin
      @(negedge clk);
      if (c == 1) begin
        start = 1'b0; op = ~op; sel = ~sel; base = ~base; stride = stride + 16'd3;
      end
      w = (c >= 3 && c <= 18);
      e = {1'(c <= 18), 1'(c == 19), 1'b0, w, 1'(c == 1), 1'b0};
      a = w ? b + 16'(c - 3) * st : 16'h0;
      d = w ? dbase + 16'(c - 3) : 16'h0;
      chk($sformatf("%s strobes c%0d", nm, c), {busy, done, mem_rd, mem_wr, vreg_rd, vreg_wr}, e);
      chk($sformatf("%s addr/data c%0d", nm, c), {mem_addr, mem_wdata}, {a, d});
      if (c == 1) chk({nm, " vreg_addr"}, vreg_addr, s);
      if (c == 18) begin last_waddr = mem_addr; last_wdata = mem_wdata; end
    end
  endtask

  initial begin
    for (int r = 0; r < 8; r++) vregs[r] = '0;
    for (int i = 0; i < 16; i++) begin
      vregs[5][16*i +: 16] = 16'h1000 + 16'(i);
      vregs[7][16*i +: 16] = 16'h7700 + 16'(i);
    end

    // Reset state
    @(negedge clk);
    @(negedge clk);
    chk("reset strobes", {busy, done, mem_rd, mem_wr, vreg_rd, vreg_wr}, 6'b0);
    chk("reset outs", {mem_addr, mem_wdata, vreg_addr}, 35'h0);
    chk("reset vreg_wdata", vreg_wdata, 256'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic load
    go(1'b0, 3'd3, 16'h0100, 16'h0001);
    watch_load("ld1", 3'd3, 16'h0100, 16'h0001, 1'b0, 1'b0);
    chk("ld1 elem0", last_vw[15:0], 16'hA4A5);
    chk("ld1 elem15", last_vw[255:240], 16'hA4AA);
    chk("ld1 first addr", rd_addr[0], 16'h0100);
    idle_cycle("ld1");

    // Basic store
    go(1'b1, 3'd5, 16'h2000, 16'h0002);
    watch_store("st1", 3'd5, 16'h2000, 16'h0002, 16'h1000);
    chk("st1 last addr", last_waddr, 16'h201E);
    chk("st1 last data", last_wdata, 16'h100F);
    idle_cycle("st1");

    // Address wrap, then zero stride
    go(1'b0, 3'd1, 16'hFFFE, 16'h0001);
    watch_load("wrap", 3'd1, 16'hFFFE, 16'h0001, 1'b0, 1'b0);
    chk("wrap a1", rd_addr[1], 16'hFFFF);
    chk("wrap a2", rd_addr[2], 16'h0000);
    chk("wrap a15", rd_addr[15], 16'h000D);
    idle_cycle("wrap");
    go(1'b0, 3'd2, 16'hFFFE, 16'h0000);
    watch_load("str0", 3'd2, 16'hFFFE, 16'h0000, 1'b0, 1'b0);
    chk("str0 a15", rd_addr[15], 16'hFFFE);
    chk("str0 elem15", last_vw[255:240], 16'h5A5B);
    idle_cycle("str0");

    // Start pulses while busy are ignored; Done pulses once
    go(1'b0, 3'd6, 16'h0040, 16'h0003);
    watch_load("poke", 3'd6, 16'h0040, 16'h0003, 1'b1, 1'b0);
    chk("poke a15", rd_addr[15], 16'h006D);
    idle_cycle("poke");
    idle_cycle("poke2");

    // Start held high through Done: next op accepted in cycle 19
    nxt_op = 1'b1; nxt_sel = 3'd5; nxt_base = 16'h0500; nxt_stride = 16'hFFFF;
    go(1'b0, 3'd4, 16'h0300, 16'h0010);
    watch_load("hold", 3'd4, 16'h0300, 16'h0010, 1'b0, 1'b1);
    watch_store("chain", 3'd5, 16'h0500, 16'hFFFF, 16'h1000);
    chk("chain last addr", last_waddr, 16'h04F1);
    idle_cycle("chain");

    // Reset in cycle 10 of a load
    go(1'b0, 3'd6, 16'h0800, 16'h0001);
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (c == 1) start = 1'b0;
    end
    chk("prerst addr", {mem_rd, mem_addr}, {1'b1, 16'h0809});
    chk("prerst vreg_addr", vreg_addr, 3'd6);
    begin
      int w0;
      w0 = vwr_cnt;
      rst_n = 1'b0;
      #1;
      chk("midrst strobes", {busy, done, mem_rd, mem_wr, vreg_rd, vreg_wr}, 6'b0);
      chk("midrst outs", {mem_addr, mem_wdata, vreg_addr}, 35'h0);
      chk("midrst vreg_wdata", vreg_wdata, 256'h0);
      for (int c = 0; c < 10; c++) @(negedge clk);
      chk("midrst held strobes", {busy, mem_rd, mem_wr, vreg_rd, vreg_wr}, 5'b0);
      rst_n = 1'b1;
      for (int c = 0; c < 10; c++) @(negedge clk);
      chk("midrst no vreg write", vwr_cnt - w0, 0);
      chk("postrst idle", {busy, done}, 2'b0);
    end
    go(1'b1, 3'd7, 16'h3000, 16'h0001);
    watch_store("st2", 3'd7, 16'h3000, 16'h0001, 16'h7700);
    chk("st2 last data", last_wdata, 16'h770F);
    idle_cycle("st2");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
